keypad_scanner: RTL and testbench
=================================

Name: keypad_scanner

Overview:
- Input-side counterpart to the seven-segment display drive.
- Scans a 4x4 active-low key matrix (Pmod KYPD style): drives one column low at a time and samples the rows.
- Debounces the result over whole scans and emits a hex key code with a one-cycle valid strobe.
- Sits beside the sseg driver, so a pressed key can be shown on the display.

Parameters:
- SCAN_DIV, 100000: clock cycles per column slot (1 ms at 100 MHz); minimum 4.
- DEBOUNCE_SCANS, 4: consecutive identical full-scan results required before acceptance; minimum 1, counter saturates here.

Ports:
- sys_clk_pin  input  1  system clock, all logic rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  scan enable, synchronous to sys_clk_pin.
- row  input  4  matrix rows, active-low, pulled up externally, asynchronous.
- col  output  4  column drive, active-low, one-cold.
- key_code  output  4  hex value of the last accepted key.
- key_valid  output  1  one-cycle pulse when a new key is accepted.
- key_held  output  1  high while the accepted key remains stably pressed.
- multi_err  output  1  high while a stable multi-key result is present.

Behaviour:
- Reset values (rst_n low, asynchronous):
  - col=4'b1111, key_code=0, key_valid=0, key_held=0, multi_err=0.
  - Column index 0, slot counter 0, snapshot cleared, stable count 0, state RELEASED.
- Row synchronizer: row passes a 2-FF synchronizer before use, adding 2 cycles of input latency.
- Column drive:
  - With en=1, col=~(4'b0001<<idx).
  - The slot counter runs 0..SCAN_DIV-1.
  - At slot count SCAN_DIV-1, the synchronized row is sampled into snapshot bits [idx*4+3:idx*4]; a row bit reads 1 when the row is low.
  - idx then advances 0->1->2->3->0, wrapping.
- Scan completion:
  - Occurs at the sample of idx=3; one scan takes 4*SCAN_DIV cycles.
  - The 16-bit snapshot is classified as NONE (0 bits), KEY(k) (exactly 1 bit, k=col*4+row), or MULTI (>1 bit).
- Key map, col0 rows0..3 = 1,4,7,0; col1 = 2,5,8,F; col2 = 3,6,9,E; col3 = A,B,C,D.
- Debounce:
  - If the classification equals the previous scan's, the stable count increments, saturating at DEBOUNCE_SCANS.
  - Otherwise the count is set to 1 and the new classification is stored.
  - A classification is "stable" when the count equals DEBOUNCE_SCANS.
  - With DEBOUNCE_SCANS=1 every scan is stable.
- FSM states RELEASED, PRESSED, evaluated only at scan completion:
  - RELEASED + stable KEY(k): key_code<=map(k), key_valid=1 on the next cycle only, key_held<=1, go to PRESSED.
  - PRESSED + stable NONE: key_held<=0, go to RELEASED.
  - PRESSED + stable KEY(j), j!=k: ignored, no roll-over; a release is required first.
  - PRESSED + stable MULTI: stays PRESSED, key_held stays 1.
  - Any state + stable MULTI: multi_err=1, never key_valid; multi_err clears at the next stable non-MULTI result.
- No repeat: a held key produces exactly one key_valid.
- key_code holds its value after release until the next accepted key.
- Disable:
  - en=0 drives col=4'b1111 and clears the slot counter, idx, snapshot and stable count.
  - It also sets state RELEASED and forces key_held=0 and multi_err=0, with no key_valid; key_code keeps its value.
  - Re-enabling starts a fresh scan at idx=0, slot count 0.
- Reset mid-scan aborts immediately to the reset values.
- Acceptance latency: a key held from the start of a scan gives key_valid 1 cycle after completion of the DEBOUNCE_SCANS-th scan.

Test Plan (SCAN_DIV=8, DEBOUNCE_SCANS=3, scan=32 cycles):
- Reset, then en=1, no keys -> col cycles 1110,1101,1011,0111 with 8 cycles each; key_valid never asserts; all outputs 0.
- Hold row[2] low while col[1]=0 (key 8) from scan start for 5 scans -> one key_valid pulse at cycle 96+1, key_code=8, key_held=1 until release.
- Release, then 3 empty scans -> key_held falls after the 3rd; a second press of key D (col3,row3) gives key_code=D with one pulse.
- Bounce: key 5 alternates present/absent on successive scans for 6 scans, then is held 3 scans -> exactly one key_valid, occurring only after the 3 stable scans.
- Keys 1 and 2 held together for 3 scans -> multi_err=1, no key_valid; release one key (2 remains) -> multi_err clears and key_code=2 with one pulse.
- en=0 while key 3 is held and key_held=1 -> col=1111, key_held=0 the next cycle, key_code stays 3; re-enable with the key held -> new key_valid after 3 scans. Assert rst_n mid-slot -> outputs reset asynchronously.

Source files
------------

// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad scanner: one column slot per SCAN_DIV cycles, whole-scan debounce, hex key code out.
// Key accepted one cycle after the DEBOUNCE_SCANS-th identical scan; no backpressure, key_valid is a single-cycle strobe.
module keypad_scanner #(
  parameter int SCAN_DIV       = 100000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       sys_clk_pin,
  input  logic       rst_n,
  input  logic       en,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held,
  output logic       multi_err
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_MAX   = CW'(DEBOUNCE_SCANS);
  localparam logic [1:0] K_NONE  = 2'd0;
  localparam logic [1:0] K_KEY   = 2'd1;
  localparam logic [1:0] K_MULTI = 2'd2;

  typedef enum logic {RELEASED, PRESSED} state_t;

  logic [3:0]    r_row_s1, r_row_s2;
  logic          r_run;
  logic [SW-1:0] r_slot;
  logic [1:0]    r_idx;
  logic [15:0]   r_snap;
  logic [5:0]    r_cls;
  logic [CW-1:0] r_cnt;
  state_t        r_state;
  logic [3:0]    r_key_code;
  logic          r_key_valid, r_key_held, r_multi_err;

  logic          w_sample, w_scan_done, w_multi, w_any, w_stable;
  logic [15:0]   w_snap;
  logic [3:0]    w_k;
  logic [5:0]    w_cls;
  logic [CW-1:0] w_cnt_next;

  function automatic logic [3:0] key_map(input logic [3:0] k);
    case (k)
      4'd0:  key_map = 4'h1;
      4'd1:  key_map = 4'h4;
      4'd2:  key_map = 4'h7;
      4'd3:  key_map = 4'h0;
      4'd4:  key_map = 4'h2;
      4'd5:  key_map = 4'h5;
      4'd6:  key_map = 4'h8;
      4'd7:  key_map = 4'hF;
      4'd8:  key_map = 4'h3;
      4'd9:  key_map = 4'h6;
      4'd10: key_map = 4'h9;
      4'd11: key_map = 4'hE;
      4'd12: key_map = 4'hA;
      4'd13: key_map = 4'hB;
      4'd14: key_map = 4'hC;
      default: key_map = 4'hD;
    endcase
  endfunction

  // r_run lags en by one cycle so the column stays released until a fresh slot 0 begins
  assign col         = r_run ? ~(4'b0001 << r_idx) : 4'b1111;
  assign w_sample    = r_run && en && (r_slot == SLOT_LAST);
  assign w_scan_done = w_sample && (r_idx == 2'd3);

  always_comb begin
    w_snap = r_snap;
    w_snap[{r_idx, 2'b00} +: 4] = ~r_row_s2;
  end

  always_comb begin
    w_k = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (w_snap[i]) w_k = 4'(i);
    end
  end

  assign w_any      = |w_snap;
  assign w_multi    = |(w_snap & (w_snap - 16'd1));
  assign w_cls      = !w_any ? {K_NONE, 4'd0} : (w_multi ? {K_MULTI, 4'd0} : {K_KEY, w_k});
  assign w_cnt_next = (w_cls != r_cls) ? CW'(1) : ((r_cnt == CNT_MAX) ? CNT_MAX : r_cnt + 1'b1);
  assign w_stable   = (w_cnt_next == CNT_MAX);

  always_ff @(posedge sys_clk_pin or negedge rst_n) begin
    if (!rst_n) begin
      r_row_s1    <= 4'hF;
      r_row_s2    <= 4'hF;
      r_run       <= 1'b0;
      r_slot      <= '0;
      r_idx       <= 2'd0;
      r_snap      <= 16'd0;
      r_cls       <= 6'd0;
      r_cnt       <= '0;
      r_state     <= RELEASED;
      r_key_code  <= 4'd0;
      r_key_valid <= 1'b0;
      r_key_held  <= 1'b0;
      r_multi_err <= 1'b0;
    end else begin
      r_row_s1    <= row;
      r_row_s2    <= r_row_s1;
      r_key_valid <= 1'b0;
      if (!en) begin
        r_run       <= 1'b0;
        r_slot      <= '0;
        r_idx       <= 2'd0;
        r_snap      <= 16'd0;
        r_cls       <= 6'd0;
        r_cnt       <= '0;
        r_state     <= RELEASED;
        r_key_held  <= 1'b0;
        r_multi_err <= 1'b0;
      end else begin
        r_run <= 1'b1;
        if (r_run) begin
          if (w_sample) begin
            r_slot <= '0;
            r_idx  <= r_idx + 1'b1;
            r_snap <= w_snap;
          end else begin
            r_slot <= r_slot + 1'b1;
          end
        end
        if (w_scan_done) begin
          r_cls <= w_cls;
          r_cnt <= w_cnt_next;
          if (w_stable) begin
            if (w_cls[5:4] == K_MULTI) begin
              r_multi_err <= 1'b1;
            end else begin
              r_multi_err <= 1'b0;
              if (r_state == RELEASED && w_cls[5:4] == K_KEY) begin
                r_key_code  <= key_map(w_cls[3:0]);
                r_key_valid <= 1'b1;
                r_key_held  <= 1'b1;
                r_state     <= PRESSED;
              end else if (r_state == PRESSED && w_cls[5:4] == K_NONE) begin
                r_key_held <= 1'b0;
                r_state    <= RELEASED;
              end
            end
          end
        end
      end
    end
  end

  assign key_code  = r_key_code;
  assign key_valid = r_key_valid;
  assign key_held  = r_key_held;
  assign multi_err = r_multi_err;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: keypad matrix model plus a table of whole-scan steps.
module tb_keypad_scanner;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;
  logic       multi_err;
  logic [15:0] keys;

  int total = 0;
  int bad   = 0;

  keypad_scanner #(.SCAN_DIV(8), .DEBOUNCE_SCANS(3)) dut (
    .sys_clk_pin(clk),
    .rst_n      (rst_n),
    .en         (en),
    .row        (row),
    .col        (col),
    .key_code   (key_code),
    .key_valid  (key_valid),
    .key_held   (key_held),
    .multi_err  (multi_err)
  );

  always #5 clk = ~clk;

  // key index k = col*4 + row pulls its row low while its column is driven low
  always_comb begin
    row = 4'hF;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (keys[c*4+r] && !col[c]) row[r] = 1'b0;
      end
    end
  end

  typedef struct {
    logic [15:0] keys;
    int          scans;
    int          pulses;
    int          first_at;
    logic [3:0]  code;
    logic        held;
    logic        err;
  } step_t;

  step_t steps[17];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  // Runs whole scans starting at a scan boundary (negedge after slot 0 begins)
  task automatic run_step(input step_t s, input int n);
    int pulses;
    int first;
    keys   = s.keys;
    pulses = 0;
    first  = -1;
    for (int i = 1; i <= s.scans * 32; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (key_valid) begin
        pulses++;
        if (first < 0) first = i;
      end
    end
    check($sformatf("step%0d_pulses", n), pulses, s.pulses);
    if (s.pulses > 0) check($sformatf("step%0d_pulse_cycle", n), first, s.first_at);
    check($sformatf("step%0d_code", n), int'(key_code), int'(s.code));
    check($sformatf("step%0d_held", n), int'(key_held), int'(s.held));
    check($sformatf("step%0d_err", n), int'(multi_err), int'(s.err));
  endtask

  initial begin
    logic [3:0] e;
    steps[0]  = '{16'h0000, 2, 0,  0, 4'h0, 1'b0, 1'b0};
    steps[1]  = '{16'h0040, 5, 1, 96, 4'h8, 1'b1, 1'b0};
    steps[2]  = '{16'h0000, 3, 0,  0, 4'h8, 1'b0, 1'b0};
    steps[3]  = '{16'h8000, 3, 1, 96, 4'hD, 1'b1, 1'b0};
    steps[4]  = '{16'h0000, 3, 0,  0, 4'hD, 1'b0, 1'b0};
    steps[5]  = '{16'h0020, 1, 0,  0, 4'hD, 1'b0, 1'b0};
    steps[6]  = '{16'h0000, 1, 0,  0, 4'hD, 1'b0, 1'b0};
    steps[7]  = '{16'h0020, 1, 0,  0, 4'hD, 1'b0, 1'b0};
    steps[8]  = '{16'h0000, 1, 0,  0, 4'hD, 1'b0, 1'b0};
    steps[9]  = '{16'h0020, 1, 0,  0, 4'hD, 1'b0, 1'b0};
    steps[10] = '{16'h0000, 1, 0,  0, 4'hD, 1'b0, 1'b0};
    steps[11] = '{16'h0020, 3, 1, 96, 4'h5, 1'b1, 1'b0};
    steps[12] = '{16'h0000, 3, 0,  0, 4'h5, 1'b0, 1'b0};
    steps[13] = '{16'h0011, 3, 0,  0, 4'h5, 1'b0, 1'b1};
    steps[14] = '{16'h0010, 3, 1, 96, 4'h2, 1'b1, 1'b0};
    steps[15] = '{16'h0000, 3, 0,  0, 4'h2, 1'b0, 1'b0};
    steps[16] = '{16'h0100, 3, 1, 96, 4'h3, 1'b1, 1'b0};

    clk   = 1'b0;
    rst_n = 1'b1;
    en    = 1'b1;
    keys  = 16'h0000;
    #3 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_col", int'(col), 4'hF);
    check("reset_code", int'(key_code), 0);
    check("reset_valid", int'(key_valid), 0);
    check("reset_held", int'(key_held), 0);
    check("reset_err", int'(multi_err), 0);

    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 32; i++) begin
      e = 4'b0001 << (i / 8);
      e = ~e;
      check($sformatf("scan_col_c%0d", i), int'(col), int'(e));
      check($sformatf("scan_valid_c%0d", i), int'(key_valid), 0);
      @(posedge clk);
      @(negedge clk);
    end

    for (int n = 0; n < 17; n++) run_step(steps[n], n);

    en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("dis_col", int'(col), 4'hF);
    check("dis_held", int'(key_held), 0);
    check("dis_code", int'(key_code), 4'h3);
    check("dis_err", int'(multi_err), 0);
    check("dis_valid", int'(key_valid), 0);
    repeat (5) @(negedge clk);
    check("dis_col_later", int'(col), 4'hF);
    en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("reen_col", int'(col), 4'hE);
    run_step(steps[16], 17);

    repeat (13) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_col", int'(col), 4'hF);
    check("mid_rst_code", int'(key_code), 0);
    check("mid_rst_valid", int'(key_valid), 0);
    check("mid_rst_held", int'(key_held), 0);
    check("mid_rst_err", int'(multi_err), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
